// File: rtl/wb_stim_slave.sv
// Wishbone stimulus slave for the Amber 128-bit bus: FIFO-fed instruction reads, captured writes.
// Define WB_STIM_ERR_EN to enable the ADDR_LO..ADDR_HI window check and the o_wb_err response.
module wb_stim_slave #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned WAIT_CYCLES = 0,
   parameter logic [31:0] FILL_WORD   = 32'hF0801003
`ifdef WB_STIM_ERR_EN
   ,
   parameter logic [31:0] ADDR_LO     = 32'h0000_0000,
   parameter logic [31:0] ADDR_HI     = 32'h0000_FFFF
`endif
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  i_wb_adr,
   input  logic [15:0]  i_wb_sel,
   input  logic         i_wb_we,
   input  logic [127:0] i_wb_dat,
   input  logic         i_wb_cyc,
   input  logic         i_wb_stb,
   output logic [127:0] o_wb_dat,
   output logic         o_wb_ack,
   output logic         o_wb_err,
   input  logic         i_inst_valid,
   input  logic [31:0]  i_inst_data,
   output logic         o_inst_ready,
   output logic         o_cap_valid,
   output logic [31:0]  o_cap_adr,
   output logic [15:0]  o_cap_sel,
   output logic [127:0] o_cap_dat,
   input  logic         i_cap_ready,
   output logic [15:0]  o_rd_count,
   output logic [15:0]  o_wr_count,
   output logic         o_underflow
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t        state;
   logic [3:0]    wait_cnt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic          req;
   logic          decide;
   logic          addr_ok;
   logic          rd_go;
   logic          wr_go;
   logic          push;
   logic          pop;
   logic [127:0]  rd_line;

   assign req    = i_wb_cyc & i_wb_stb;
   assign decide = (state == ST_WAIT) && req && (wait_cnt == 4'd0);

`ifdef WB_STIM_ERR_EN
   assign addr_ok = (i_wb_adr >= ADDR_LO) && (i_wb_adr <= ADDR_HI);
`else
   assign addr_ok = 1'b1;
`endif

   // A write waits at the decision point until the capture slot is free or being drained.
   assign rd_go = decide & addr_ok & ~i_wb_we;
   assign wr_go = decide & addr_ok & i_wb_we & (~o_cap_valid | i_cap_ready);

   assign o_inst_ready = (count != (AW+1)'(DEPTH));
   assign push         = i_inst_valid & o_inst_ready;
   assign pop          = rd_go & (count != '0);

   always_comb begin
      rd_line = {4{FILL_WORD}};
      if (count != '0)
         rd_line[{i_wb_adr[3:2], 5'b0} +: 32] = mem[rd_ptr];
   end

   // NOTE: the instruction store is not reset; pointers and count alone define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= i_inst_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   // NOTE: non-blocking assignments throughout so every output is a clean register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         wait_cnt    <= 4'd0;
         o_wb_ack    <= 1'b0;
         o_wb_dat    <= '0;
         o_rd_count  <= '0;
         o_wr_count  <= '0;
         o_underflow <= 1'b0;
         o_cap_valid <= 1'b0;
         o_cap_adr   <= '0;
         o_cap_sel   <= '0;
         o_cap_dat   <= '0;
      end else begin
         o_wb_ack <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (req) begin
                  state    <= ST_WAIT;
                  wait_cnt <= 4'(WAIT_CYCLES);
               end
            end
            ST_WAIT: begin
               if (!req)
                  state <= ST_IDLE;
               else if (wait_cnt != 4'd0)
                  wait_cnt <= wait_cnt - 4'd1;
               else if (!addr_ok || rd_go || wr_go) begin
                  state    <= ST_RESP;
                  o_wb_ack <= addr_ok;
               end
            end
            default: state <= ST_IDLE;
         endcase

         if (rd_go) begin
            o_wb_dat   <= rd_line;
            o_rd_count <= o_rd_count + 16'd1;
            if (count == '0)
               o_underflow <= 1'b1;
         end

         if (wr_go) begin
            o_cap_valid <= 1'b1;
            o_cap_adr   <= i_wb_adr;
            o_cap_sel   <= i_wb_sel;
            o_cap_dat   <= i_wb_dat;
            o_wr_count  <= o_wr_count + 16'd1;
         end else if (i_cap_ready) begin
            o_cap_valid <= 1'b0;
         end
      end
   end

`ifdef WB_STIM_ERR_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         o_wb_err <= 1'b0;
      else
         o_wb_err <= decide & ~addr_ok;
   end
`else
   assign o_wb_err = 1'b0;
`endif

endmodule
